// File: rtl/atm_mem_pkg.sv
// Shared widths, arbiter state encoding and memory command bundle for the
// fetch/LSU memory port arbiter.
package atm_mem_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int MASK_W = 4;
    localparam int LAT_W  = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_F = 2'd1,
        BUSY_D = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [MASK_W-1:0] wmask;
    } mem_cmd_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/mem_lat_timer.sv
// Counts the fixed memory latency of the one outstanding access.
// load restarts the count at MEM_LAT; done marks the response cycle.
import atm_mem_pkg::*;

module mem_lat_timer #(
    parameter int MEM_LAT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic busy,
    output logic done
);

    logic [LAT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LAT_W'(MEM_LAT);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - LAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);
    assign done = (cnt_q == LAT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency memory port between fetch and LSU: data first, starvation guard for fetch.
// Optional ARB_PERF_CNT_EN adds saturating stall/grant/drop performance counters.
import atm_mem_pkg::*;

module mem_port_arbiter #(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic [15:0] fetch_addr,
    output logic        fetch_gnt,
    output logic        fetch_stall,
    output logic        fetch_rvalid,
    output logic [31:0] fetch_rdata,
    input  logic        flush,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [15:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_wmask,
    output logic        data_gnt,
    output logic        data_rvalid,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
`ifdef ARB_PERF_CNT_EN
    output logic [31:0] perf_fetch_stall_cyc,
    output logic [31:0] perf_data_gnt,
    output logic [31:0] perf_fetch_drop,
`endif
    input  logic [31:0] mem_rdata
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    arb_state_e    state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          drop_q, drop_d;
    logic          rst_dly_q;

    logic     lat_busy, lat_done;
    logic     fetch_elig, port_free, arb_en;
    logic     data_win, fetch_win, issue, resp;
    mem_cmd_t cmd;

    mem_lat_timer #(.MEM_LAT(MEM_LAT)) u_lat_timer (
        .clk   (clk),
        .reset (reset),
        .load  (issue),
        .busy  (lat_busy),
        .done  (lat_done)
    );

    always_comb begin
        fetch_elig = fetch_req && !flush;
        port_free  = (state_q == IDLE) || !lat_busy || lat_done;
        // The cycle right after reset is kept quiet: no grants issued.
        arb_en     = port_free && !reset && !rst_dly_q;
        data_win   = arb_en && data_req && !((starve_q == STARVE_LIM) && fetch_elig);
        fetch_win  = arb_en && !data_win && fetch_elig;
        issue      = data_win || fetch_win;
        resp       = lat_done && !reset;

        state_d = state_q;
        if (port_free) begin
            if (data_win) begin
                state_d = BUSY_D;
            end else if (fetch_win) begin
                state_d = BUSY_F;
            end else begin
                state_d = IDLE;
            end
        end

        starve_d = starve_q;
        if (fetch_win) begin
            starve_d = '0;
        end else if (data_win && fetch_elig) begin
            if (starve_q != STARVE_LIM) begin
                starve_d = starve_q + SW'(1);
            end
        end else if (port_free && !fetch_elig) begin
            starve_d = '0;
        end

        // Drop flag lives only for the fetch transaction it was raised in.
        drop_d = drop_q;
        if ((state_q != BUSY_F) || lat_done) begin
            drop_d = 1'b0;
        end else if (flush) begin
            drop_d = 1'b1;
        end

        if (data_win) begin
            cmd = '{we: data_we, addr: data_addr, wdata: data_wdata, wmask: data_wmask};
        end else begin
            cmd = '{we: 1'b0, addr: fetch_addr, wdata: '0, wmask: '0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            starve_q  <= '0;
            drop_q    <= 1'b0;
            rst_dly_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            drop_q    <= drop_d;
            rst_dly_q <= 1'b0;
        end
    end

    assign fetch_gnt    = fetch_win;
    assign data_gnt     = data_win;
    assign fetch_stall  = fetch_req && !fetch_win;
    assign fetch_rvalid = resp && (state_q == BUSY_F) && !drop_q && !flush;
    assign data_rvalid  = resp && (state_q == BUSY_D);
    assign fetch_rdata  = mem_rdata;
    assign data_rdata   = mem_rdata;

    assign mem_req   = issue;
    assign mem_we    = cmd.we;
    assign mem_addr  = cmd.addr;
    assign mem_wdata = cmd.wdata;
    assign mem_wmask = cmd.wmask;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_dgnt_q, perf_dgnt_d;
    logic [31:0] perf_drop_q, perf_drop_d;

    always_comb begin
        perf_stall_d = fetch_stall ? sat_inc32(perf_stall_q) : perf_stall_q;
        perf_dgnt_d  = data_win ? sat_inc32(perf_dgnt_q) : perf_dgnt_q;
        perf_drop_d  = (resp && (state_q == BUSY_F) && (drop_q || flush))
                       ? sat_inc32(perf_drop_q) : perf_drop_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_q <= '0;
            perf_dgnt_q  <= '0;
            perf_drop_q  <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_dgnt_q  <= perf_dgnt_d;
            perf_drop_q  <= perf_drop_d;
        end
    end

    assign perf_fetch_stall_cyc = perf_stall_q;
    assign perf_data_gnt        = perf_dgnt_q;
    assign perf_fetch_drop      = perf_drop_q;
`endif

endmodule
